alu_seq: RTL and testbench

Multi-cycle, width-parametrised successor to the single-cycle CPU ALU. Single-cycle ops complete in one clock. MUL (signed, shift-add) and DIV (unsigned, restoring) iterate over WIDTH clocks. The execute stage drives it with a START/BUSY/DONE handshake. All results and flags are registered, and a write-back qualifier is provided.

---
 rtl/alu_seq.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : multi-cycle, width-parametrised ALU for the execute stage.
//
// Single-cycle ops register their result on the START edge. MUL (signed,
// shift-add) and DIV (unsigned, restoring) iterate for WIDTH clocks while BUSY
// is high. DIV by zero bypasses iteration and completes like a single-cycle op.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous, active-high reset
//   START      in   operation request, sampled only while BUSY=0
//   ALUX       in   opcode [3:0]
//   ARGA/ARGB  in   operands [WIDTH-1:0]
//   BUSY       out  multi-cycle operation in flight
//   DONE       out  one-cycle pulse; RESULT, RESULT_HI, WB and flags valid
//   RESULT     out  primary result
//   RESULT_HI  out  MUL high word / DIV remainder, 0 otherwise
//   WB         out  write-back enable, 0 for CMP
//   SIGN, CARRY, ZERO, OVFL, PARITY  out  registered flags
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [3:0]       ALUX,
    input  logic [WIDTH-1:0] ARGA,
    input  logic [WIDTH-1:0] ARGB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             WB,
    output logic             SIGN,
    output logic             CARRY,
    output logic             ZERO,
    output logic             OVFL,
    output logic             PARITY
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    localparam logic [3:0] OP_MOV = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_MUL = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4,  OP_AND = 4'd5,  OP_XOR = 4'd6,  OP_SL  = 4'd7;
    localparam logic [3:0] OP_SR  = 4'd8,  OP_SRA = 4'd9,  OP_ROT = 4'd10, OP_DIV = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12, OP_SET = 4'd13, OP_CLR = 4'd14, OP_SEX = 4'd15;

    // FSM and iteration state
    state_t               state_q, state_d;
    logic [SHW-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;        // MUL partial product
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;    // sign-extended A, shifted left per step
    logic [WIDTH-1:0]     mplier_q, mplier_d;  // B, shifted right per step
    logic [WIDTH-1:0]     rem_q, rem_d;        // DIV partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;        // DIV dividend in, quotient out
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;

    // Registered outputs
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 done_q, done_d;
    logic                 wb_q, wb_d;
    logic                 sign_q, sign_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 ovfl_q, ovfl_d;
    logic                 parity_q, parity_d;

    // Single-cycle datapath
    logic [WIDTH-1:0]     sc_res, sc_hi;
    logic                 sc_carry, sc_ovfl;
    logic [WIDTH:0]       add_w, sub_w, sl_w;
    logic [WIDTH-1:0]     bit_w;
    logic [SHW-1:0]       sh_lo;
    logic                 b_big;

    // Iteration datapath and completion write port
    logic [2*WIDTH-1:0]   mul_add, acc_nx;
    logic [WIDTH:0]       rem_sh, div_try;
    logic [WIDTH-1:0]     rem_nx, quo_nx;
    logic                 wr_en, wr_carry, wr_ovfl, wr_wb;
    logic [WIDTH-1:0]     wr_res, wr_hi;

    // -------------------------------------------------------------------------
    // Single-cycle ALU, evaluated straight from the inputs on the START edge.
    // -------------------------------------------------------------------------
    always_comb begin : alu_comb
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave it unassigned and infer a latch.
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovfl  = 1'b0;

        sh_lo = ARGB[SHW-1:0];
        // WIDTH is a power of two, so B >= WIDTH iff any bit above the count field is set.
        b_big = |ARGB[WIDTH-1:SHW];
        add_w = {1'b0, ARGA} + {1'b0, ARGB};
        sub_w = {1'b0, ARGA} - {1'b0, ARGB};
        // The extra top bit catches the last bit shifted out; it is A[0] when B==WIDTH
        // and 0 for B==0 or B>WIDTH, which is exactly the required SL carry.
        sl_w  = {1'b0, ARGA} << ARGB;
        bit_w = {{(WIDTH-1){1'b0}}, 1'b1} << sh_lo;

        case (ALUX)
            OP_MOV: sc_res = ARGB;
            OP_ADD: begin
                sc_res   = add_w[WIDTH-1:0];
                sc_carry = add_w[WIDTH];
                sc_ovfl  = (ARGA[WIDTH-1] == ARGB[WIDTH-1]) && (add_w[WIDTH-1] != ARGA[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                sc_res   = sub_w[WIDTH-1:0];
                sc_carry = sub_w[WIDTH];
                sc_ovfl  = (ARGA[WIDTH-1] != ARGB[WIDTH-1]) && (sub_w[WIDTH-1] != ARGA[WIDTH-1]);
            end
            OP_OR:  sc_res = ARGA | ARGB;
            OP_AND: sc_res = ARGA & ARGB;
            OP_XOR: sc_res = ARGA ^ ARGB;
            OP_SL: begin
                sc_res   = sl_w[WIDTH-1:0];
                sc_carry = sl_w[WIDTH];
            end
            OP_SR:  sc_res = ARGA >> ARGB;
            OP_SRA: begin
                // Kept out of a ternary: mixing with an unsigned arm would turn >>> logical.
                if (b_big) sc_res = {WIDTH{ARGA[WIDTH-1]}};
                else       sc_res = $signed(ARGA) >>> sh_lo;
            end
            OP_ROT: sc_res = (ARGA >> sh_lo) | (ARGA << (WIDTH - int'(sh_lo)));
            OP_DIV: begin
                // Only reached for a zero divisor; non-zero divisors iterate.
                sc_res  = '1;
                sc_hi   = ARGA;
                sc_ovfl = 1'b1;
            end
            OP_SET: sc_res = ARGA | bit_w;
            OP_CLR: sc_res = ARGA & ~bit_w;
            OP_SEX: begin
                for (int i = 0; i < WIDTH; i++)
                    sc_res[i] = (i <= int'(sh_lo)) ? ARGA[i] : ARGA[sh_lo];
            end
            default: ;  // OP_MUL never completes here
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // Every register, datapath included, clears so an aborted op leaves no trace.
            state_q     <= S_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            done_q      <= 1'b0;
            wb_q        <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovfl_q      <= 1'b0;
            parity_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            done_q      <= done_d;
            wb_q        <= wb_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovfl_q      <= ovfl_d;
            parity_q    <= parity_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin : next_state_comb
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        wb_d        = wb_q;
        sign_d      = sign_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovfl_d      = ovfl_q;
        parity_d    = parity_q;
        done_d      = 1'b0;

        wr_en    = 1'b0;
        wr_res   = '0;
        wr_hi    = '0;
        wr_carry = 1'b0;
        wr_ovfl  = 1'b0;
        wr_wb    = 1'b0;

        // Shift-add step; the final step carries the negative weight of B's sign bit.
        mul_add = mplier_q[0] ? mcand_q : '0;
        acc_nx  = (&count_q) ? (acc_q - mul_add) : (acc_q + mul_add);

        // Restoring division step; a set top bit of the trial means it went negative.
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        div_try = rem_sh - {1'b0, dvsr_q};
        rem_nx  = div_try[WIDTH] ? rem_sh[WIDTH-1:0] : div_try[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], ~div_try[WIDTH]};

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (ALUX == OP_MUL) begin
                        state_d  = S_MUL;
                        count_d  = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{ARGA[WIDTH-1]}}, ARGA};
                        mplier_d = ARGB;
                    end else if (ALUX == OP_DIV && ARGB != '0) begin
                        state_d = S_DIV;
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = ARGA;
                        dvsr_d  = ARGB;
                    end else begin
                        wr_en    = 1'b1;
                        wr_res   = sc_res;
                        wr_hi    = sc_hi;
                        wr_carry = sc_carry;
                        wr_ovfl  = sc_ovfl;
                        wr_wb    = (ALUX != OP_CMP);
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (&count_q) begin
                    state_d = S_IDLE;
                    wr_en   = 1'b1;
                    wr_res  = acc_nx[WIDTH-1:0];
                    wr_hi   = acc_nx[2*WIDTH-1:WIDTH];
                    // Overflow when the high word is not just the sign of the low word.
                    wr_ovfl = (acc_nx[2*WIDTH-1:WIDTH] != {WIDTH{acc_nx[WIDTH-1]}});
                    wr_wb   = 1'b1;
                end
            end
            S_DIV: begin
                rem_d   = rem_nx;
                quo_d   = quo_nx;
                count_d = count_q + 1'b1;
                if (&count_q) begin
                    state_d = S_IDLE;
                    wr_en   = 1'b1;
                    wr_res  = quo_nx;
                    wr_hi   = rem_nx;
                    wr_wb   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            result_d    = wr_res;
            result_hi_d = wr_hi;
            wb_d        = wr_wb;
            carry_d     = wr_carry;
            ovfl_d      = wr_ovfl;
            sign_d      = wr_res[WIDTH-1];
            zero_d      = (wr_res == '0);
            parity_d    = ^wr_res;
            done_d      = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin : output_comb
        BUSY      = (state_q != S_IDLE);
        DONE      = done_q;
        RESULT    = result_q;
        RESULT_HI = result_hi_q;
        WB        = wb_q;
        SIGN      = sign_q;
        CARRY     = carry_q;
        ZERO      = zero_q;
        OVFL      = ovfl_q;
        PARITY    = parity_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq.
// One WIDTH=16 instance carries most vectors; a WIDTH=32 instance covers the
// wide MUL and SEX cases. Flags are compared as {SIGN,CARRY,ZERO,OVFL,PARITY}.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam logic [3:0] OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_MUL = 4'd3,  OP_SL  = 4'd7;
    localparam logic [3:0] OP_SR  = 4'd8,  OP_SRA = 4'd9,  OP_ROT = 4'd10, OP_DIV = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12, OP_SET = 4'd13, OP_CLR = 4'd14, OP_SEX = 4'd15;

    logic        clk = 1'b0;
    logic        rst;

    logic        start16;
    logic [3:0]  alux16;
    logic [15:0] a16, b16, res16, hi16;
    logic        busy16, done16, wb16, sign16, carry16, zero16, ovfl16, par16;
    logic [4:0]  flg16;

    logic        start32;
    logic [3:0]  alux32;
    logic [31:0] a32, b32, res32, hi32;
    logic        busy32, done32, wb32, sign32, carry32, zero32, ovfl32, par32;
    logic [4:0]  flg32;

    int checks   = 0;
    int failures = 0;
    int lat, busy_n, cnt_a, cnt_b;

    always #5 clk = ~clk;

    assign flg16 = {sign16, carry16, zero16, ovfl16, par16};
    assign flg32 = {sign32, carry32, zero32, ovfl32, par32};

    alu_seq #(.WIDTH(16)) dut16 (
        .CLK(clk), .RESET(rst), .START(start16), .ALUX(alux16), .ARGA(a16), .ARGB(b16),
        .BUSY(busy16), .DONE(done16), .RESULT(res16), .RESULT_HI(hi16), .WB(wb16),
        .SIGN(sign16), .CARRY(carry16), .ZERO(zero16), .OVFL(ovfl16), .PARITY(par16)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .CLK(clk), .RESET(rst), .START(start32), .ALUX(alux32), .ARGA(a32), .ARGB(b32),
        .BUSY(busy32), .DONE(done32), .RESULT(res32), .RESULT_HI(hi32), .WB(wb32),
        .SIGN(sign32), .CARRY(carry32), .ZERO(zero32), .OVFL(ovfl32), .PARITY(par32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an op for one edge, then scrambles the inputs to prove they were latched.
    task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alux16  = op;
        a16     = a;
        b16     = b;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        a16     = 16'hDEAD;
        b16     = 16'hBEEF;
    endtask

    // Counts edges after the START edge until DONE (bounded by max_cyc) and the
    // samples with BUSY high. At iteration pulse_at an ADD request is pulsed.
    task automatic wait_done16(input int max_cyc, input int pulse_at, output int n_lat, output int n_busy);
        n_lat  = 0;
        n_busy = 0;
        while (!done16 && n_lat < max_cyc) begin
            if (busy16) n_busy++;
            if (n_lat == pulse_at) begin
                alux16  = OP_ADD;
                a16     = 16'h0001;
                b16     = 16'h0001;
                start16 = 1'b1;
            end
            tick();
            start16 = 1'b0;
            n_lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start16 = 1'b0; alux16 = '0; a16 = '0; b16 = '0;
        start32 = 1'b0; alux32 = '0; a32 = '0; b32 = '0;
        tick();
        tick();
        check("reset_result", res16, 16'h0000);
        check("reset_hi",     hi16,  16'h0000);
        check("reset_ctl",    {busy16, done16, wb16}, 3'b000);
        check("reset_flags",  flg16, 5'b00000);
        #2 rst = 1'b0;
        tick();

        // ADD 0x7FFF+1: signed overflow, single cycle.
        issue16(OP_ADD, 16'h7FFF, 16'h0001);
        wait_done16(40, -1, lat, busy_n);
        check("add_lat",    lat,    0);
        check("add_busy",   busy_n, 0);
        check("add_result", res16,  16'h8000);
        check("add_hi",     hi16,   16'h0000);
        check("add_wb",     wb16,   1'b1);
        check("add_flags",  flg16,  5'b10011);
        tick();
        check("add_done_pulse", done16, 1'b0);
        check("add_hold",       res16,  16'h8000);

        // MUL -3*5.
        issue16(OP_MUL, 16'hFFFD, 16'h0005);
        wait_done16(40, -1, lat, busy_n);
        check("mul1_lat",    lat,    16);
        check("mul1_busy",   busy_n, 16);
        check("mul1_result", res16,  16'hFFF1);
        check("mul1_hi",     hi16,   16'hFFFF);
        check("mul1_flags",  flg16,  5'b10001);
        check("mul1_busy_end", busy16, 1'b0);

        // MUL 0x4000*4 with an ADD request pulsed mid-operation.
        tick();
        issue16(OP_MUL, 16'h4000, 16'h0004);
        wait_done16(40, 5, lat, busy_n);
        check("mul2_lat",    lat,   16);
        check("mul2_result", res16, 16'h0000);
        check("mul2_hi",     hi16,  16'h0001);
        check("mul2_flags",  flg16, 5'b00110);
        tick();
        check("mul2_no_queue", {busy16, done16}, 2'b00);

        // DIV 100/7, then SUB 3-5 issued in the DONE cycle.
        issue16(OP_DIV, 16'd100, 16'd7);
        wait_done16(40, -1, lat, busy_n);
        check("div_lat",    lat,   16);
        check("div_result", res16, 16'd14);
        check("div_hi",     hi16,  16'd2);
        check("div_flags",  flg16, 5'b00001);
        issue16(OP_SUB, 16'd3, 16'd5);
        check("b2b_done",   done16, 1'b1);
        check("b2b_result", res16,  16'hFFFE);
        check("b2b_flags",  flg16,  5'b11001);

        // DIV by zero finishes in one cycle.
        tick();
        issue16(OP_DIV, 16'h1234, 16'h0000);
        wait_done16(40, -1, lat, busy_n);
        check("div0_lat",    lat,    0);
        check("div0_busy",   busy_n, 0);
        check("div0_result", res16,  16'hFFFF);
        check("div0_hi",     hi16,   16'h1234);
        check("div0_flags",  flg16,  5'b10010);

        // Shifts and bit ops: {op, A, B, expected result, expected flags}.
        issue16(OP_SL, 16'h8001, 16'd1);
        check("sl1_result", res16, 16'h0002);  check("sl1_flags", flg16, 5'b01001);
        issue16(OP_SL, 16'h0001, 16'd16);
        check("sl16_result", res16, 16'h0000); check("sl16_flags", flg16, 5'b01100);
        issue16(OP_SL, 16'h0003, 16'd0);
        check("sl0_result", res16, 16'h0003);  check("sl0_flags", flg16, 5'b00000);
        issue16(OP_SRA, 16'h8000, 16'd20);
        check("sra_result", res16, 16'hFFFF);  check("sra_flags", flg16, 5'b10000);
        issue16(OP_ROT, 16'h0001, 16'd17);
        check("rot_result", res16, 16'h8000);  check("rot_flags", flg16, 5'b10001);
        issue16(OP_SR, 16'hFFFF, 16'd16);
        check("sr_result", res16, 16'h0000);   check("sr_flags", flg16, 5'b00100);
        issue16(OP_SET, 16'h0000, 16'h0013);
        check("set_result", res16, 16'h0008);
        issue16(OP_CLR, 16'hFFFF, 16'h000F);
        check("clr_result", res16, 16'h7FFF);  check("clr_flags", flg16, 5'b00001);
        check("shift_hi", hi16, 16'h0000);

        // RESET during iteration 5 of a DIV.
        tick();
        issue16(OP_DIV, 16'd100, 16'd7);
        for (int i = 0; i < 5; i++) tick();
        check("rst_pre_busy", busy16, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_result", res16, 16'h0000);
        check("rst_mid_hi",     hi16,  16'h0000);
        check("rst_mid_ctl",    {busy16, done16, wb16}, 3'b000);
        check("rst_mid_flags",  flg16, 5'b00000);
        #1 rst = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done16) cnt_a++;
            if (busy16) cnt_b++;
        end
        check("rst_no_done", cnt_a, 0);
        check("rst_no_busy", cnt_b, 0);

        // CMP 5,7 after the abort.
        issue16(OP_CMP, 16'd5, 16'd7);
        check("cmp_done",   done16, 1'b1);
        check("cmp_wb",     wb16,   1'b0);
        check("cmp_result", res16,  16'hFFFE);
        check("cmp_flags",  flg16,  5'b11001);

        // WIDTH=32: MUL -1*-1.
        alux32 = OP_MUL; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
        tick();
        start32 = 1'b0; a32 = 32'h1357_9BDF; b32 = 32'h0246_8ACE;
        lat = 0;
        busy_n = 0;
        while (!done32 && lat < 80) begin
            if (busy32) busy_n++;
            tick();
            lat++;
        end
        check("mul32_lat",    lat,    32);
        check("mul32_busy",   busy_n, 32);
        check("mul32_result", res32,  32'h0000_0001);
        check("mul32_hi",     hi32,   32'h0000_0000);
        check("mul32_flags",  flg32,  5'b00001);

        // WIDTH=32: SEX 0x80 from bit 7.
        alux32 = OP_SEX; a32 = 32'h0000_0080; b32 = 32'd7; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        check("sex32_done",   {done32, busy32, wb32}, 3'b101);
        check("sex32_result", res32, 32'hFFFF_FF80);
        check("sex32_flags",  flg32, 5'b10001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
